// File: rtl/vtg_pkg.sv
// Shared constants for the video timing generator: register map and the
// 640x480 power-on timing.
package vtg_pkg;
  typedef enum logic [2:0] {
    REG_HACT = 3'd0, REG_HFP = 3'd1, REG_HSW = 3'd2, REG_HBP = 3'd3,
    REG_VACT = 3'd4, REG_VFP = 3'd5, REG_VSW = 3'd6, REG_VBP = 3'd7
  } vtg_reg_e;

  localparam int NREG      = 8;
  localparam int DEF_HACT  = 640;
  localparam int DEF_HFP   = 16;
  localparam int DEF_HSW   = 96;
  localparam int DEF_HBP   = 48;
  localparam int DEF_VACT  = 480;
  localparam int DEF_VFP   = 10;
  localparam int DEF_VSW   = 2;
  localparam int DEF_VBP   = 33;
  localparam int DEF_DIV   = 3;
  localparam bit DEF_ILACE = 1'b0;
endpackage

// File: rtl/vtg_axis.sv
// One timing axis: position counter with wrap, sync window and active flag.
// Order along the axis is active, front porch, sync, back porch.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          adv,
  input  logic [CW-1:0] act,
  input  logic [CW-1:0] fp,
  input  logic [CW-1:0] sw,
  input  logic [CW-1:0] bp,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          sync,
  output logic          active
);
  localparam int TW = CW + 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] act_e, sw_e, sync_beg, sync_end, tot, cnt_x;
  logic          last;

  // Zero-length active/sync regions are treated as one unit long.
  always_comb begin
    act_e    = (act == '0) ? TW'(1) : TW'(act);
    sw_e     = (sw == '0) ? TW'(1) : TW'(sw);
    sync_beg = act_e + TW'(fp);
    sync_end = sync_beg + sw_e;
    tot      = sync_end + TW'(bp);
    cnt_x    = TW'(cnt_q);
    last     = (cnt_x >= tot - TW'(1));
    wrap     = adv && last;
    sync     = (cnt_x >= sync_beg) && (cnt_x < sync_end);
    active   = (cnt_x < act_e);
    cnt_d    = cnt_q;
    if (adv) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator. A shadow register set is written at
// any time and swapped into the live timing only at the end of a frame.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic [3:0]    cfg_div,
  input  logic          cfg_ilace,
  input  logic          cfg_commit,
  output logic          cfg_pending,
  output logic          ce_pix,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic          f1,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          new_vmode
);
  localparam logic [NREG-1:0][CW-1:0] DEF_SET = {
    CW'(DEF_VBP), CW'(DEF_VSW), CW'(DEF_VFP), CW'(DEF_VACT),
    CW'(DEF_HBP), CW'(DEF_HSW), CW'(DEF_HFP), CW'(DEF_HACT)
  };

  logic [NREG-1:0][CW-1:0] sh_q, sh_d, cur_q, cur_d;
  logic [3:0]    div_sh_q, div_sh_d, div_q, div_d, dcnt_q, dcnt_d;
  logic          ilace_sh_q, ilace_sh_d, ilace_q, ilace_d;
  logic          field_q, field_d, pending_q, pending_d, new_vmode_q, new_vmode_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, f1_q, f1_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          ce, apply, h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;

  assign ce    = (dcnt_q == div_q);
  // v_wrap only fires on an h wrap, which only fires on ce: the frame boundary.
  assign apply = v_wrap && (pending_q || cfg_commit);

  vtg_axis #(.CW(CW)) u_h (
    .clk_vid(clk_vid), .reset(reset), .adv(ce),
    .act(cur_q[REG_HACT]), .fp(cur_q[REG_HFP]), .sw(cur_q[REG_HSW]), .bp(cur_q[REG_HBP]),
    .cnt(h_cnt), .wrap(h_wrap), .sync(h_sync), .active(h_act)
  );

  vtg_axis #(.CW(CW)) u_v (
    .clk_vid(clk_vid), .reset(reset), .adv(h_wrap),
    .act(cur_q[REG_VACT]), .fp(cur_q[REG_VFP]), .sw(cur_q[REG_VSW]), .bp(cur_q[REG_VBP]),
    .cnt(v_cnt), .wrap(v_wrap), .sync(v_sync), .active(v_act)
  );

  always_comb begin
    sh_d = sh_q;
    if (cfg_wr) sh_d[cfg_addr] = cfg_data;
    div_sh_d    = cfg_commit ? cfg_div : div_sh_q;
    ilace_sh_d  = cfg_commit ? cfg_ilace : ilace_sh_q;
    // The live set takes the shadow as it stood before this edge's write.
    cur_d       = apply ? sh_q : cur_q;
    div_d       = apply ? div_sh_d : div_q;
    ilace_d     = apply ? ilace_sh_d : ilace_q;
    dcnt_d      = ce ? 4'd0 : dcnt_q + 4'd1;
    pending_d   = !apply && (pending_q || cfg_commit);
    new_vmode_d = new_vmode_q ^ apply;
    field_d     = field_q;
    if (apply || !ilace_q) field_d = 1'b0;
    else if (v_wrap)       field_d = ~field_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    f1_d   = f1_q;
    if (ce) begin
      hcnt_d = h_cnt;
      vcnt_d = v_cnt;
      de_d   = h_act && v_act;
      hs_d   = h_sync;
      vs_d   = v_sync;
      f1_d   = field_q;
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      sh_q        <= DEF_SET;
      cur_q       <= DEF_SET;
      div_sh_q    <= 4'(DEF_DIV);
      div_q       <= 4'(DEF_DIV);
      ilace_sh_q  <= DEF_ILACE;
      ilace_q     <= DEF_ILACE;
      dcnt_q      <= '0;
      field_q     <= 1'b0;
      pending_q   <= 1'b0;
      new_vmode_q <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      f1_q        <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      cur_q       <= cur_d;
      div_sh_q    <= div_sh_d;
      div_q       <= div_d;
      ilace_sh_q  <= ilace_sh_d;
      ilace_q     <= ilace_d;
      dcnt_q      <= dcnt_d;
      field_q     <= field_d;
      pending_q   <= pending_d;
      new_vmode_q <= new_vmode_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      f1_q        <= f1_d;
    end
  end

  assign cfg_pending = pending_q;
  assign ce_pix      = ce;
  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign f1          = f1_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign new_vmode   = new_vmode_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench: a frame-level raster model queues the expected pixel stream
// and a negedge monitor compares every ce_pix output against it.
module tb_video_timing_gen;
  localparam int CW = 12;

  logic          clk_vid = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr = 1'b0, cfg_ilace = 1'b0, cfg_commit = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [3:0]    cfg_div = '0;
  logic          cfg_pending, ce_pix, de, hs, vs, f1, new_vmode;
  logic [CW-1:0] hcnt, vcnt;

  video_timing_gen #(.CW(CW)) dut (
    .clk_vid(clk_vid), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_div(cfg_div), .cfg_ilace(cfg_ilace),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .ce_pix(ce_pix),
    .de(de), .hs(hs), .vs(vs), .f1(f1), .hcnt(hcnt), .vcnt(vcnt),
    .new_vmode(new_vmode)
  );

  always #5 clk_vid = ~clk_vid;

  typedef struct packed {
    logic [7:0][15:0] f;
    logic [3:0]       div;
    logic             ilace;
  } cfg_t;

  typedef struct packed {
    logic [15:0] h, v;
    logic        de, hs, vs, f1, last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  cfg_t cur, sh;
  logic [3:0] pdiv;
  logic pil, pend, nv, ce_prev;
  int gen_y, fcnt, gap;
  int total = 0, bad = 0;

  function automatic cfg_t def_cfg();
    cfg_t c;
    c.f = {16'd33, 16'd2, 16'd10, 16'd480, 16'd48, 16'd96, 16'd16, 16'd640};
    c.div = 4'd3;
    c.ilace = 1'b0;
    return c;
  endfunction

  function automatic int sat1(int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int htot_of(cfg_t c);
    return sat1(int'(c.f[0])) + int'(c.f[1]) + sat1(int'(c.f[2])) + int'(c.f[3]);
  endfunction

  function automatic int vtot_of(cfg_t c);
    return sat1(int'(c.f[4])) + int'(c.f[5]) + sat1(int'(c.f[6])) + int'(c.f[7]);
  endfunction

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Appends one full raster line of expected pixels for the live mode.
  function automatic void gen_line();
    int ha, hf, hw, ht, va, vf, vw, vt;
    exp_t x_e;
    ha = sat1(int'(cur.f[0])); hf = int'(cur.f[1]); hw = sat1(int'(cur.f[2]));
    va = sat1(int'(cur.f[4])); vf = int'(cur.f[5]); vw = sat1(int'(cur.f[6]));
    ht = htot_of(cur);
    vt = vtot_of(cur);
    for (int x = 0; x < ht; x++) begin
      x_e.h    = 16'(x);
      x_e.v    = 16'(gen_y);
      x_e.de   = (x < ha) && (gen_y < va);
      x_e.hs   = (x >= ha + hf) && (x < ha + hf + hw);
      x_e.vs   = (gen_y >= va + vf) && (gen_y < va + vf + vw);
      x_e.f1   = cur.ilace && fcnt[0];
      x_e.last = (gen_y == vt - 1) && (x == ht - 1);
      q.push_back(x_e);
    end
    gen_y++;
    if (gen_y >= vt) begin
      gen_y = 0;
      fcnt++;
    end
  endfunction

  function automatic void model_init();
    q.delete();
    cur = def_cfg();
    sh = def_cfg();
    pdiv = 4'd3; pil = 1'b0; pend = 1'b0; nv = 1'b0; ce_prev = 1'b0;
    gen_y = 0; fcnt = 0; gap = 0;
    gen_line();
  endfunction

  always @(negedge clk_vid) begin
    if (reset) begin
      chk("rst_hcnt", int'(hcnt), 0);
      chk("rst_vcnt", int'(vcnt), 0);
      chk("rst_sync", {de, hs, vs, f1}, 0);
      chk("rst_pending", int'(cfg_pending), 0);
      chk("rst_new_vmode", int'(new_vmode), 0);
      model_init();
    end else begin
      bit applied;
      applied = 1'b0;
      if (ce_prev) begin
        e = q.pop_front();
        chk("hcnt", int'(hcnt), int'(e.h));
        chk("vcnt", int'(vcnt), int'(e.v));
        chk("de", int'(de), int'(e.de));
        chk("hs", int'(hs), int'(e.hs));
        chk("vs", int'(vs), int'(e.vs));
        chk("f1", int'(f1), int'(e.f1));
        if (q.size() == 0) gen_line();
      end
      chk("cfg_pending", int'(cfg_pending), int'(pend));
      chk("new_vmode", int'(new_vmode), int'(nv));
      gap++;
      if (ce_pix || gap > int'(cur.div) + 1) begin
        chk("ce_period", gap, int'(cur.div) + 1);
        gap = 0;
      end
      // Upcoming edge is the last pixel of the frame: mode switch point.
      if (ce_pix && q[0].last && (pend || cfg_commit)) begin
        cur.f     = sh.f;
        cur.div   = cfg_commit ? cfg_div : pdiv;
        cur.ilace = cfg_commit ? cfg_ilace : pil;
        pend      = 1'b0;
        nv        = ~nv;
        fcnt      = 0;
        applied   = 1'b1;
      end
      if (cfg_wr) sh.f[cfg_addr] = 16'(cfg_data);
      if (cfg_commit && !applied) begin
        pend = 1'b1;
        pdiv = cfg_div;
        pil  = cfg_ilace;
      end
      ce_prev = ce_pix;
    end
  end

  task automatic tick();
    @(posedge clk_vid);
    #2;
  endtask

  task automatic wr(int a, int d);
    cfg_wr = 1'b1; cfg_addr = 3'(a); cfg_data = CW'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic wr_all(logic [7:0][15:0] r);
    for (int i = 0; i < 8; i++) wr(i, int'(r[i]));
  endtask

  task automatic commit(int dv, bit il);
    cfg_commit = 1'b1; cfg_div = 4'(dv); cfg_ilace = il;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_toggle(int budget);
    logic n0;
    int n;
    n0 = new_vmode;
    n = 0;
    while (new_vmode == n0 && n < budget) begin
      tick();
      n++;
    end
    if (new_vmode == n0) chk("toggle_timeout", n, -1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0][15:0] r;
    int n;
    #2;
    do_reset();
    // Commit pending during default timing, then reset part way down the frame.
    r = {16'd3, 16'd2, 16'd2, 16'd6, 16'd5, 16'd4, 16'd3, 16'd20};
    wr_all(r);
    commit(1, 1'b0);
    n = 0;
    while (vcnt != CW'(3) && n < 20000) begin tick(); n++; end
    if (vcnt != CW'(3)) chk("vcnt_timeout", int'(vcnt), 3);
    do_reset();
    // One full default frame, then a mode with zero sync widths and interlace.
    r = {16'd2, 16'd0, 16'd1, 16'd4, 16'd3, 16'd0, 16'd2, 16'd10};
    wr_all(r);
    commit(0, 1'b1);
    wait_toggle(1750000);
    repeat (600) tick();
    commit(0, 1'b0);
    wait_toggle(2000);
    repeat (300) tick();
    // Two commits in one frame with HACT rewritten between them.
    wr(0, 12);
    commit(1, 1'b0);
    wr(0, 7);
    commit(1, 1'b1);
    wait_toggle(5000);
    repeat (400) tick();
    // Commit landing exactly on the frame boundary edge.
    n = 0;
    while (!(ce_pix && int'(hcnt) == htot_of(cur) - 2 && int'(vcnt) == vtot_of(cur) - 1)
           && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) chk("boundary_timeout", n, -1);
    commit(2, 1'b0);
    repeat (500) tick();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 8; i++) begin
        case (i)
          0:       r[i] = 16'($urandom_range(24, 0));
          4:       r[i] = 16'($urandom_range(8, 0));
          2, 6:    r[i] = 16'($urandom_range(5, 0));
          default: r[i] = 16'($urandom_range(4, 0));
        endcase
      end
      repeat ($urandom_range(30, 0)) tick();
      wr_all(r);
      commit(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) begin
        wr(0, int'($urandom_range(24, 1)));
        commit(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      end
      wait_toggle(20000);
      repeat ($urandom_range(400, 0)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
